// File: rtl/imm_gen_queue.sv
// Immediate generator with a DEPTH-entry output queue between decode and execute.
// Immediates are formed at write time; the head entry drives the outputs.
module imm_gen_queue #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 32,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_din,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic [CW-1:0]    count
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_I     = 3'd1,
    OP_U     = 3'd2,
    OP_SHIFT = 3'd3,
    OP_S     = 3'd4,
    OP_B     = 3'd5,
    OP_J     = 3'd6,
    OP_ZIMM  = 3'd7
  } op_e;

  logic [XLEN-1:0]  imm_q [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic             ill_q [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [63:0]     wide;
  logic [XLEN-1:0] imm_d;
  logic            ill_d;
  logic            push, pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Built at 64 bits so every format sign-extends the same way, then trimmed.
  always_comb begin
    wide  = '0;
    ill_d = 1'b0;
    unique case (op_e'(in_op))
      OP_I:     wide = {{52{in_din[24]}}, in_din[24:13]};
      OP_U:     wide = {{32{in_din[24]}}, in_din[24:5], 12'b0};
      OP_SHIFT: begin
        if (XLEN == 64) wide = {58'b0, in_din[18:13]};
        else            wide = {59'b0, in_din[17:13]};
        ill_d = (XLEN == 32) && in_din[18];
      end
      OP_S:     wide = {{52{in_din[24]}}, in_din[24:18], in_din[4:0]};
      OP_B:     wide = {{51{in_din[24]}}, in_din[24], in_din[0],
                        in_din[23:18], in_din[4:1], 1'b0};
      OP_J:     wide = {{43{in_din[24]}}, in_din[24], in_din[12:5],
                        in_din[13], in_din[23:14], 1'b0};
      OP_ZIMM:  wide = {59'b0, in_din[12:8]};
      OP_NONE:  wide = '0;
    endcase
    imm_d = wide[XLEN-1:0];
  end

  assign in_ready  = (cnt_q < CW'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_imm     = imm_q[rptr_q];
  assign out_tag     = tag_q[rptr_q];
  assign out_illegal = ill_q[rptr_q];
  assign count       = cnt_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = inc(wptr_q);
      if (pop)  rptr_d = inc(rptr_q);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        imm_q[i] <= '0;
        tag_q[i] <= '0;
        ill_q[i] <= 1'b0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (push && !flush) begin
        imm_q[wptr_q] <= imm_d;
        tag_q[wptr_q] <= in_tag;
        ill_q[wptr_q] <= ill_d;
      end
    end
  end

endmodule

// File: doc/imm_gen_queue.md
Name: imm_gen_queue

Overview:
- Parametrised, pipelined successor to the decode-stage immediate generator.
- Accepts instr[31:7] plus an extension-format code and a passthrough tag (typically the PC) over a valid/ready handshake.
- Produces an XLEN-wide immediate through a DEPTH-entry output queue, decoupling decode from execute.
- Adds RV64 shift-amount handling, a CSR zero-extended immediate, an illegal-shift flag and a synchronous flush for branch redirects.

Parameters:
- XLEN, 32, immediate width; legal values are 32 or 64.
- DEPTH, 2, number of output queue entries; legal range 1..8.
- TAG_W, 32, width of the passthrough tag.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous queue clear.
- in_valid  in  1  input beat valid.
- in_ready  out  1  queue can accept a beat.
- in_din  in  25  instr[31:7].
- in_op  in  3  format code: 0 NONE, 1 I, 2 U, 3 SHIFT, 4 S, 5 B, 6 J, 7 ZIMM.
- in_tag  in  TAG_W  passthrough tag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes the head entry.
- out_imm  out  XLEN  head immediate.
- out_tag  out  TAG_W  head tag.
- out_illegal  out  1  head entry flagged illegal.
- count  out  clog2(DEPTH+1)  current occupancy.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset state: count=0, out_valid=0, out_imm=0, out_tag=0, out_illegal=0, read and write pointers=0.
- Accept/pop: a beat is accepted when in_valid && in_ready. A pop occurs when out_valid && out_ready.
- in_ready = (count < DEPTH). It is not combinationally dependent on out_ready, so a full queue stalls even when a pop occurs in the same cycle.
- Latency: an accepted beat is visible at the head on the next cycle when the queue was empty. There is no combinational input-to-output path.
- Ordering: strictly FIFO. The head outputs hold stable while out_valid && !out_ready.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointer wrap: pointers wrap modulo DEPTH; DEPTH need not be a power of two.
- Flush (synchronous): count becomes 0, pointers reset to 0 and out_valid becomes 0 on the next edge.
  - A beat accepted in the same cycle as flush is discarded.
  - A pop in the same cycle as flush is ignored for state purposes.
- Stale entries: out_imm/out_tag may hold stale data while out_valid=0.
- Immediate computation happens at write time; d = in_din. Every result is sign-extended to XLEN unless stated otherwise.
  - I: d[24:13].
  - U: {d[24:5], 12'b0}; for XLEN=64, sign-extended from bit 31.
  - SHIFT: zero-extended shamt, d[17:13] for XLEN=32 and d[18:13] for XLEN=64.
  - S: {d[24:18], d[4:0]}.
  - B: {d[24], d[0], d[23:18], d[4:1], 1'b0}.
  - J: {d[24], d[12:5], d[13], d[23:14], 1'b0}.
  - ZIMM: zero-extended d[12:8] (rs1 field, CSR*I).
  - NONE: 0.
- Illegal flag: out_illegal=1 for SHIFT with XLEN=32 and d[18]=1 (instr[25]); the shamt is still computed from d[17:13]. All other codes give 0.
- Reset mid-operation: rst_n low clears all queued entries immediately, asynchronously; in_ready=1 after release.
- Input rules: in_valid may drop without acceptance. Inputs must be stable only in the cycle they are accepted.

Test Plan:
- Basic I: reset, accept din=0x1FFE001 (addi x1,x0,-1), op=1 (I), tag=0x80000000 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_tag=0x80000000, out_illegal=0.
- Format sweep, XLEN=32:
  - U, din=0x02468A1 -> 0x12345000.
  - B, encoding offset -4 -> 0xFFFFFFFC.
  - J, encoding offset +2048 -> 0x00000800.
  - ZIMM, rs1=31 -> 0x0000001F.
  - NONE -> 0.
- RV64 shift and U, XLEN=64:
  - SHIFT with d[18:13]=0x3F -> out_imm=63, out_illegal=0.
  - Same stimulus at XLEN=32 -> out_imm=31, out_illegal=1.
  - U with d[24]=1 at XLEN=64 -> upper 32 bits all ones.
- Full and backpressure, DEPTH=2:
  - Hold out_ready=0 and push 3 beats -> the third stalls with in_ready=0 and count=2.
  - Raise out_ready for one cycle -> first tag popped, count=1, in_ready=1 the following cycle; order preserved.
- Flush:
  - With count=2, assert flush together with in_valid -> next cycle count=0, out_valid=0, and the pushed beat never appears.
  - Assert rst_n low asynchronously mid-stream -> outputs 0 before the next edge.
